// File: rtl/fifo_cdc_pkg.sv
// rtl/fifo_cdc_pkg.sv - shared Gray/binary helpers and depth constants for the async FIFO controllers
package fifo_cdc_pkg;

  localparam int PTR_MAX_W = 32;

  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  // Callers zero-extend into PTR_MAX_W bits and cast the result back to their own pointer type.
  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/async_fifo_wr_ctrl_if.sv
// rtl/async_fifo_wr_ctrl_if.sv - producer/synchroniser-facing signals of the FIFO write controller
interface async_fifo_wr_ctrl_if #(
  parameter int ADDR_W = 3
);
  logic              wr_en;
  logic [ADDR_W:0]   rptr_gray_sync;
  logic              clr_overflow;
  logic              wr_accept;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W:0]   wptr_gray;
  logic              full;
  logic              almost_full;
  logic [ADDR_W:0]   wr_level;
  logic              overflow;

  modport master (
    output wr_en, rptr_gray_sync, clr_overflow,
    input  wr_accept, waddr, wptr_gray, full, almost_full, wr_level, overflow
  );

  modport slave (
    input  wr_en, rptr_gray_sync, clr_overflow,
    output wr_accept, waddr, wptr_gray, full, almost_full, wr_level, overflow
  );
endinterface

// File: rtl/async_fifo_wr_ctrl.sv
// rtl/async_fifo_wr_ctrl.sv - write-domain pointer, full/almost_full and level logic of the async FIFO
module async_fifo_wr_ctrl
  import fifo_cdc_pkg::*;
#(
  parameter int ADDR_W    = 3,
  parameter int AF_MARGIN = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  async_fifo_wr_ctrl_if.slave  wif
);

  localparam int DEPTH = fifo_depth(ADDR_W);
  localparam int PW    = ADDR_W + 1;
  localparam logic [PW-1:0] AF_THRESH = PW'(DEPTH - AF_MARGIN);

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] gray_q, gray_d;
  logic [PW-1:0] level_q, level_d;
  logic [PW-1:0] rbin;
  logic          full_q, full_d;
  logic          af_q, af_d;
  logic          ovf_q, ovf_d;
  logic          wr_accept;

  always_comb begin
    wr_accept = wif.wr_en & ~full_q;
    wbin_d    = wbin_q + PW'(wr_accept);
    gray_d    = PW'(bin2gray(PTR_MAX_W'(wbin_d)));
    rbin      = PW'(gray2bin(PTR_MAX_W'(wif.rptr_gray_sync)));
    level_d   = wbin_d - rbin;
    // Full in Gray space: wrap bit and next bit inverted, the rest equal.
    full_d    = (gray_d == {~wif.rptr_gray_sync[ADDR_W:ADDR_W-1],
                            wif.rptr_gray_sync[ADDR_W-2:0]});
    af_d      = (level_d >= AF_THRESH);
    ovf_d     = (wif.wr_en & full_q) | (ovf_q & ~wif.clr_overflow);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q  <= '0;
      gray_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      gray_q  <= gray_d;
      level_q <= level_d;
      full_q  <= full_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
    end
  end

  assign wif.wr_accept   = wr_accept;
  assign wif.waddr       = wbin_q[ADDR_W-1:0];
  assign wif.wptr_gray   = gray_q;
  assign wif.full        = full_q;
  assign wif.almost_full = af_q;
  assign wif.wr_level    = level_q;
  assign wif.overflow    = ovf_q;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// tb/tb_async_fifo_wr_ctrl.sv - self-checking bench for async_fifo_wr_ctrl against an occupancy model
module tb_async_fifo_wr_ctrl;

  localparam int AW  = 3;
  localparam int D   = 8;
  localparam int PM  = 16;
  localparam int AFM = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  async_fifo_wr_ctrl_if #(.ADDR_W(AW)) bus ();

  async_fifo_wr_ctrl #(.ADDR_W(AW), .AF_MARGIN(AFM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wif   (bus.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  // Inverse by search over the pointer space rather than by bit recursion.
  function automatic int ungray(input int g);
    for (int r = 0; r < PM; r++) if (gray(r) == g) return r;
    return -1;
  endfunction

  // Model: unsigned pointer counts and occupancy.
  int m_wb, m_lvl;
  bit m_full, m_af, m_ovf;

  always @(posedge clk or negedge rst_n) begin
    int acc;
    if (!rst_n) begin
      m_wb = 0; m_lvl = 0; m_full = 0; m_af = 0; m_ovf = 0;
    end else begin
      acc   = (bus.wr_en && !m_full) ? 1 : 0;
      m_ovf = (bus.wr_en && m_full) || (m_ovf && !bus.clr_overflow);
      m_wb  = (m_wb + acc) % PM;
      m_lvl = (m_wb - ungray(int'(bus.rptr_gray_sync)) + PM) % PM;
      m_full = (m_lvl == D);
      m_af   = (m_lvl >= D - AFM);
    end
  end

  bit cmp_en = 0;
  int prev_gray = 0;
  bit saw_wrap = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_gray = 0;
    end else if (cmp_en) begin
      check("wr_accept", int'(bus.wr_accept), (bus.wr_en && !m_full) ? 1 : 0);
      check("waddr", int'(bus.waddr), m_wb % D);
      check("wptr_gray", int'(bus.wptr_gray), gray(m_wb));
      check("full", int'(bus.full), int'(m_full));
      check("almost_full", int'(bus.almost_full), int'(m_af));
      check("wr_level", int'(bus.wr_level), m_lvl);
      check("overflow", int'(bus.overflow), int'(m_ovf));
      check("gray_step_bits", ($countones(int'(bus.wptr_gray) ^ prev_gray) <= 1) ? 1 : 0, 1);
      if (prev_gray == 8 && int'(bus.wptr_gray) == 0) saw_wrap = 1;
      prev_gray = int'(bus.wptr_gray);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_in(input bit w, input int rg, input bit c);
    bus.wr_en          = w;
    bus.rptr_gray_sync = (AW+1)'(rg);
    bus.clr_overflow   = c;
  endtask

  int seq[8] = '{1, 3, 2, 6, 7, 5, 4, 12};
  int rb_drv;

  initial begin
    set_in(0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_wptr_gray", int'(bus.wptr_gray), 0);
    check("rst_level", int'(bus.wr_level), 0);
    rst_n = 1'b1;
    cmp_en = 1;

    // Fill eight slots with the reader idle.
    for (int i = 0; i < 8; i++) begin
      set_in(1, 0, 0);
      #1;
      check("fill_waddr", int'(bus.waddr), i);
      check("fill_accept", int'(bus.wr_accept), 1);
      tick();
      check("fill_gray", int'(bus.wptr_gray), seq[i]);
      check("fill_level", int'(bus.wr_level), i + 1);
      check("fill_af", int'(bus.almost_full), (i + 1 >= 7) ? 1 : 0);
    end
    check("fill_full", int'(bus.full), 1);

    // Overflow set, clear, and set-wins-over-clear.
    for (int i = 0; i < 2; i++) begin
      set_in(1, 0, 0);
      #1;
      check("ovf_accept", int'(bus.wr_accept), 0);
      tick();
      check("ovf_gray_hold", int'(bus.wptr_gray), 12);
      check("ovf_set", int'(bus.overflow), 1);
    end
    set_in(0, 0, 1);
    tick();
    check("ovf_clear", int'(bus.overflow), 0);
    set_in(1, 0, 1);
    tick();
    check("ovf_set_wins", int'(bus.overflow), 1);
    set_in(0, 0, 1);
    tick();

    // Reader advances to binary 3.
    set_in(0, 2, 0);
    tick();
    check("drain_full", int'(bus.full), 0);
    check("drain_level", int'(bus.wr_level), 5);
    check("drain_af", int'(bus.almost_full), 0);
    set_in(1, 2, 0);
    tick();
    check("drain_write_level", int'(bus.wr_level), 6);

    // Reader trails so the level settles at 2 while pointers wrap.
    for (int i = 0; i < 40; i++) begin
      set_in(1, gray((m_wb + 1 - 2 + PM) % PM), 0);
      tick();
      check("wrap_full", int'(bus.full), 0);
      check("wrap_level", int'(bus.wr_level), 2);
    end
    check("wrap_seen", int'(saw_wrap), 1);

    // Asynchronous reset mid-stream with a write pending.
    set_in(1, gray((m_wb + 1 - 2 + PM) % PM), 0);
    rst_n = 1'b0;
    #1;
    check("arst_gray", int'(bus.wptr_gray), 0);
    check("arst_full", int'(bus.full), 0);
    check("arst_level", int'(bus.wr_level), 0);
    check("arst_ovf", int'(bus.overflow), 0);
    set_in(0, 0, 0);
    tick();
    rst_n = 1'b1;

    // wbin=7, write accepted while the reader moves to 1.
    for (int i = 0; i < 7; i++) begin
      set_in(1, 0, 0);
      tick();
    end
    set_in(1, 1, 0);
    tick();
    check("bound_full", int'(bus.full), 0);
    check("bound_level", int'(bus.wr_level), 7);
    check("bound_af", int'(bus.almost_full), 1);

    // Random traffic; reader never passes the writer.
    rb_drv = 1;
    for (int i = 0; i < 800; i++) begin
      bit rd_fast;
      rd_fast = ((i / 100) % 2) == 1;
      if (((m_wb - rb_drv + PM) % PM) > 0 && ($urandom % (rd_fast ? 2 : 5)) == 0)
        rb_drv = (rb_drv + 1) % PM;
      set_in(($urandom % 4) != 0, gray(rb_drv), ($urandom % 8) == 0);
      tick();
    end

    set_in(0, gray(rb_drv), 0);
    tick();
    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
